// File: rtl/nios_keys_pkg.sv
// nios_keys_pkg
//   Shared definitions for the key/switch input PIO: register word
//   addresses, EDGE_MODE encodings and a constant-safe ceil(log2) helper.
package nios_keys_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,  // debounced input levels, read-only
    ADDR_RSVD = 2'd1,  // reads 0, writes ignored
    ADDR_MASK = 2'd2,  // interrupt mask, read/write
    ADDR_EDGE = 2'd3   // edge capture, write-1-to-clear
  } addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nios_keys_pio_edge_debounce.sv
// keys_debounce_bit
//   One input channel: SYNC_STAGES-deep synchroniser followed by a
//   stable-count debouncer. The debounced value only follows the
//   synchronised input after DEBOUNCE_CYCLES consecutive mismatching cycles.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     din          : raw asynchronous input bit
//     deb          : debounced level
module keys_debounce_bit
  import nios_keys_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: the synchroniser output is the debounced value.
      assign deb = sync;
    end else begin : g_filter
      localparam int             CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             deb_q;
      logic             deb_d;

      // The counter holds the number of mismatching cycles already seen;
      // the cycle that would make it DEBOUNCE_CYCLES commits the new level
      // instead, so the counter never exceeds DEBOUNCE_CYCLES-1.
      always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync != deb_q) begin
          if (cnt_q == CNT_LAST) begin
            deb_d = sync;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
          deb_q <= IDLE_LEVEL;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign deb = deb_q;
    end
  endgenerate

endmodule

// File: rtl/nios_keys_pio_edge.sv
// nios_keys_pio_edge
//   Avalon-MM input PIO for push-buttons/switches with per-channel
//   synchronise + debounce, edge capture (write-1-to-clear) and a maskable
//   level interrupt.
//   Ports:
//     clk, reset_n         : clock, asynchronous active-low reset
//     address[1:0]         : word address (DATA / reserved / MASK / EDGE)
//     chipselect/read/write: slave strobes
//     writedata[31:0]      : write data
//     in_port[WIDTH-1:0]   : raw asynchronous key inputs
//     readdata[31:0]       : registered read data, one cycle latency
//     irq                  : registered level interrupt
module nios_keys_pio_edge
  import nios_keys_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_MODE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_prev_q,  deb_prev_d;
  logic [WIDTH-1:0] capture_q,   capture_d;
  logic [WIDTH-1:0] mask_q,      mask_d;
  logic [31:0]      readdata_q,  readdata_d;
  logic             irq_q,       irq_d;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;

  // Read data is driven whenever selected, so the read strobe itself is not
  // needed; the write data bits above WIDTH are ignored by design.
  logic unused_ok;
  assign unused_ok = &{1'b0, read, writedata};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      keys_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[gi]),
        .deb    (deb[gi])
      );
    end
  endgenerate

  always_comb begin
    rise = deb & ~deb_prev_q;
    fall = ~deb & deb_prev_q;
    if (EDGE_MODE == EDGE_RISE) begin
      edge_set = rise;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_set = fall;
    end else begin
      edge_set = rise | fall;
    end
  end

  always_comb begin
    wr_en      = chipselect & write;
    deb_prev_d = deb;

    edge_clr = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
    // Set is ORed in after the clear so a same-cycle edge is never lost.
    capture_d = (capture_q & ~edge_clr) | edge_set;

    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end

    irq_d = |(capture_q & mask_q);

    // Held at zero when not selected to keep the bus quiet.
    readdata_d = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata_d = 32'(deb);
        ADDR_MASK: readdata_d = 32'(mask_q);
        ADDR_EDGE: readdata_d = 32'(capture_q);
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev_q <= {WIDTH{IDLE_LEVEL}};
      capture_q  <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb_prev_d;
      capture_q  <= capture_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/nios_keys_pio_edge.md
Name: nios_keys_pio_edge

Overview:
Parametrised Avalon-MM input PIO for push-buttons and switches, WIDTH channels wide. Each input is synchronised, debounced, and has its edges detected. Edges latch into a write-1-to-clear capture register, which drives a maskable level interrupt to the Nios II. It is the successor to the single-bit, poll-only key port and sits on the system interconnect as a slave with one IRQ line.

Parameters:
WIDTH, 4, number of input channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before the debounced value changes; 0 = debounce bypassed
EDGE_MODE, 1, edge that sets capture: 0 rising, 1 falling, 2 any
IDLE_LEVEL, 1, reset value of the synchroniser and debounced value (keys are active-low, idle high)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  word address
chipselect  in  1  slave select
read  in  1  read strobe, qualified by chipselect
write  in  1  write strobe, qualified by chipselect
writedata  in  32  write data
in_port  in  WIDTH  raw asynchronous key inputs
readdata  out  32  registered read data
irq  out  1  level interrupt request

Behaviour:
- Reset (async assert, sync release): readdata=0, irq=0, mask=0, edge_capture=0. Synchroniser flops and debounced value = {WIDTH{IDLE_LEVEL}}. Debounce counters = 0.
- Synchroniser: SYNC_STAGES flops per bit. in_port is never used unsynchronised.
- Debounce, per bit: while sync != deb, the counter increments. A mismatch lasting DEBOUNCE_CYCLES consecutive cycles updates deb <= sync and clears the counter. Any cycle with sync == deb clears the counter. The counter is $clog2(DEBOUNCE_CYCLES+1) bits and never wraps. With DEBOUNCE_CYCLES=0, deb = sync with no added latency.
- Edge detect: deb_prev is registered. rise = deb & ~deb_prev; fall = ~deb & deb_prev; selected per EDGE_MODE.
- Register map (address):
  - 0 DATA, RO: deb in bits [WIDTH-1:0], upper bits 0. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK, RW: bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGE_CAPTURE, RW1C: a bit is set by the selected edge, and writing 1 clears it.
- Simultaneous edge and clear on the same bit in the same cycle: set wins, so the bit stays 1.
- Read latency 1: readdata is updated on every clk with the mux of address. readdata is don't-care to the master unless the read was qualified. It is held at 0 when chipselect=0 to reduce toggling.
- Writes take effect on the clk edge where chipselect & write. Read-then-write in consecutive cycles is legal.
- irq = |(edge_capture & mask), registered: it asserts 1 cycle after the capture bit or mask bit becomes set, and deasserts 1 cycle after the clear or unmask.
- Latency from an in_port change to the capture bit set: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles, plus 1 more for irq.
- A glitch shorter than DEBOUNCE_CYCLES never changes deb and never sets capture.
- Reset mid-debounce: the counter is discarded and deb returns to IDLE_LEVEL. No spurious edge after release, because deb_prev also resets to IDLE_LEVEL.

Decomposition:
- Package nios_keys_pkg:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_MODE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY
  - function clog2
- Sub-module keys_debounce_bit: holds the synchroniser, counter and deb flop for one bit, parameters SYNC_STAGES/DEBOUNCE_CYCLES/IDLE_LEVEL, generated WIDTH times.
- The top level holds the edge logic, registers, readdata mux and irq.

Test Plan:
1. Reset, WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=1, in_port=4'hF → DATA reads 0xF, MASK 0, EDGE 0, irq 0. Also assert reset mid-operation and confirm the same values.
2. Drive in_port[2]=0 held for 10 cycles → EDGE reads 0x4 exactly SYNC_STAGES+5 cycles after the change. DATA reads 0xB. irq stays 0 while MASK=0.
3. Write MASK=0x4 → irq=1 one cycle later. Write EDGE=0x4 → irq=0 one cycle later and EDGE reads 0.
4. Pulse in_port[0] low for 3 cycles (< DEBOUNCE_CYCLES) → DATA stays 0xF, EDGE stays 0, irq stays 0.
5. Align a debounced falling edge on bit 1 with a write of EDGE=0x2 in the same cycle → EDGE reads 0x2 (set wins).
6. EDGE_MODE=2, DEBOUNCE_CYCLES=0, toggle in_port[3] 1→0→1 → EDGE bit 3 is set after each toggle. Clearing it between toggles re-sets it. Reading address 1 returns 0.
